// File: rtl/seq_ctrl_pkg.sv
// Package for the step-sequence controller.
// Holds the FSM state encoding, the run-mode constants and the reset contents
// of the step table. Reset contents are entries 0..7 = 7,3,1,0,2,4,6,7.
// Entries past index 7 in a deeper table reset to 7.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [1:0] MODE_CONT   = 2'd0;
  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_BURST  = 2'd2;

  // Packed so that element [i] is table entry i.
  // The concatenation lists element 7 first.
  localparam logic [7:0][2:0] DEFAULT_TABLE = {3'd7, 3'd6, 3'd4, 3'd2,
                                               3'd0, 3'd1, 3'd3, 3'd7};

  function automatic logic [2:0] default_entry(input int unsigned i);
    logic [2:0] sel;
    sel = i[2:0];
    if (i < 8) return DEFAULT_TABLE[sel];
    else       return 3'd7;
  endfunction

endpackage

// File: rtl/seq_step_table.sv
// seq_step_table: DEPTH x WIDTH step register file.
// Writes are synchronous and reads are asynchronous.
// Rst reloads the default step table.
// Ports:
//   Clk, Rst        clock, synchronous active-high reset (reloads defaults)
//   Wr_en           write strobe (already gated by the controller)
//   Wr_addr/Wr_data write address / data
//   Rd_addr         read address
//   Rd_data         combinational read data
module seq_step_table
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Wr_en,
  input  logic [AW-1:0]    Wr_addr,
  input  logic [WIDTH-1:0] Wr_data,
  input  logic [AW-1:0]    Rd_addr,
  output logic [WIDTH-1:0] Rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(default_entry(i));
      end
    end else if (Wr_en) begin
      mem[Wr_addr] <= Wr_data;
    end
  end

  assign Rd_data = mem[Rd_addr];

endmodule

// File: rtl/seq_step_controller.sv
// seq_step_controller: plays out the programmable step table.
// The controller runs under Start/Stop control in continuous, single-step or
// counted-burst mode. It raises a one-cycle Done pulse when a run ends.
//
// Optional feature macro: SEQ_CTRL_REVERSE_EN.
//   When the macro is defined, the controller adds a Dir input, sampled with Start.
//   With Dir=1, playback starts at Len-1 and counts down, wrapping from 0 back to Len-1.
//
// Ports:
//   Clk, Rst        clock, synchronous active-high reset
//   Start, Stop     run request (sampled in IDLE) / abort (sampled in RUN)
//   Mode            0 continuous, 1 single, 2 burst, 3 behaves as single
//   Burst_len, Len  burst step count and active table length, sampled with Start
//   Wr_en/addr/data table write port, ignored while Busy
//   State, Idx      current step value and its table index
//   Valid, Busy     new step this cycle / FSM not idle
//   Done            one-cycle completion pulse
//   Fsm_state       FSM state for observation
//
// Handshake: no backpressure.
//   Valid=1 marks exactly one new State/Idx pair in that cycle.
//   Done is high only in the single DONE cycle that follows the last Valid step.
module seq_step_controller
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Stop,
  input  logic [1:0]       Mode,
  input  logic [CNT_W-1:0] Burst_len,
  input  logic [AW:0]      Len,
`ifdef SEQ_CTRL_REVERSE_EN
  input  logic             Dir,
`endif
  input  logic             Wr_en,
  input  logic [AW-1:0]    Wr_addr,
  input  logic [WIDTH-1:0] Wr_data,
  output logic [WIDTH-1:0] State,
  output logic             Valid,
  output logic             Busy,
  output logic             Done,
  output logic [AW-1:0]    Idx,
  output logic [1:0]       Fsm_state
);

  fsm_t             fsm_q, fsm_d;
  logic [1:0]       mode_q;
  logic [AW:0]      len_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    idx_q;
  logic [WIDTH-1:0] state_q;
  logic             dir_q;

  logic [AW:0]      len_in_eff;
  logic [AW-1:0]    last_in, last_q, first_idx, next_idx, rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [1:0]       mode_in_eff;
  logic             dir_in, finish;

`ifdef SEQ_CTRL_REVERSE_EN
  assign dir_in = Dir;
`else
  assign dir_in = 1'b0;
`endif

  // Len of 0 or anything above DEPTH means "use the whole table".
  assign len_in_eff  = (Len == '0 || Len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : Len;
  assign last_in     = AW'(len_in_eff - 1'b1);
  assign last_q      = AW'(len_q - 1'b1);
  assign mode_in_eff = (Mode == 2'd3) ? MODE_SINGLE : Mode;
  assign first_idx   = dir_in ? last_in : '0;

  always_comb begin
    next_idx = '0;
    if (dir_q) next_idx = (idx_q == '0)     ? last_q : idx_q - 1'b1;
    else       next_idx = (idx_q == last_q) ? '0     : idx_q + 1'b1;
  end

  // One read port serves both the first step (looked up from live inputs
  // in IDLE) and each following step (looked up from the latched run).
  assign rd_addr = (fsm_q == IDLE) ? first_idx : next_idx;

  // The current RUN step is the last one of the run.
  assign finish = (mode_q == MODE_SINGLE) ||
                  (mode_q == MODE_BURST && cnt_q == CNT_W'(1));

  seq_step_table #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_table (
    .Clk     (Clk),
    .Rst     (Rst),
    .Wr_en   (Wr_en && (fsm_q == IDLE)),
    .Wr_addr (Wr_addr),
    .Wr_data (Wr_data),
    .Rd_addr (rd_addr),
    .Rd_data (rd_data)
  );

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (Rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  // FSM: next state
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (Start) fsm_d = RUN;
      RUN:     if (Stop || finish) fsm_d = DONE;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    Valid     = (fsm_q == RUN);
    Busy      = (fsm_q != IDLE);
    Done      = (fsm_q == DONE);
    Fsm_state = fsm_q;
  end

  // Run parameters, index, step value and burst counter
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mode_q  <= MODE_CONT;
      len_q   <= (AW+1)'(DEPTH);
      cnt_q   <= CNT_W'(1);
      idx_q   <= '0;
      state_q <= WIDTH'(default_entry(0));
      dir_q   <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: if (Start) begin
          mode_q  <= mode_in_eff;
          len_q   <= len_in_eff;
          cnt_q   <= (Burst_len == '0) ? CNT_W'(1) : Burst_len;
          dir_q   <= dir_in;
          idx_q   <= first_idx;
          state_q <= rd_data;
        end
        RUN: if (fsm_d == RUN) begin
          idx_q   <= next_idx;
          state_q <= rd_data;
          cnt_q   <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign State = state_q;
  assign Idx   = idx_q;

endmodule
